// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage WISC pipeline: load-use stall, branch squash,
// memory-busy freeze and memory-timeout watchdog. Define HAZARD_PERF_CNT_EN to build the stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int REG_W       = 4,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_is_load,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_branch_taken,
  input  logic             mem_busy,
  output logic             PC_stall,
  output logic             IF_ID_stall,
  output logic             IF_flush,
  output logic             ID_EX_flush,
  output logic             EX_MEM_stall,
  output logic             MEM_WB_flush,
  output logic             hazard_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT < 1) ? 0 : MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_ERR      = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WAIT_W-1:0]  r_wait_cnt;
  logic [WAIT_W-1:0]  w_wait_cnt_nxt;
  logic               r_ex_load_vld;
  logic [REG_W-1:0]   r_ex_rd;
  logic               w_lu;
  logic               w_mem_hold;
  logic               w_err;

  assign w_err      = (r_state == S_ERR);
  assign w_mem_hold = (r_state != S_ERR) && mem_busy;

  // R0 is hardwired zero, so a load targeting it can never create a real dependency.
  assign w_lu = id_valid && r_ex_load_vld && (r_ex_rd != '0) &&
                ((id_uses_rs && (id_rs == r_ex_rd)) || (id_uses_rt && (id_rt == r_ex_rd)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_load_vld <= 1'b0;
      r_ex_rd       <= '0;
    end else if (!EX_MEM_stall) begin
      r_ex_load_vld <= id_valid && id_is_load && !ID_EX_flush;
      r_ex_rd       <= id_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_RUN;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  // The counter holds the number of busy cycles already completed before the current one.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    case (r_state)
      S_RUN: begin
        if (mem_busy) begin
          if (MEM_TIMEOUT <= 1) begin
            w_state_nxt = S_ERR;
          end else begin
            w_state_nxt    = S_MEM_WAIT;
            w_wait_cnt_nxt = WAIT_W'(1);
          end
        end
      end
      S_MEM_WAIT: begin
        if (!mem_busy) begin
          w_state_nxt    = S_RUN;
          w_wait_cnt_nxt = '0;
        end else if (r_wait_cnt >= WAIT_LAST) begin
          w_state_nxt = S_ERR;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
        end
      end
      S_ERR: begin
        w_state_nxt = S_ERR;
      end
      default: begin
        w_state_nxt    = S_RUN;
        w_wait_cnt_nxt = '0;
      end
    endcase
  end

  // Priority: memory freeze / error, then load-use bubble, then branch squash.
  always_comb begin
    PC_stall     = 1'b0;
    IF_ID_stall  = 1'b0;
    IF_flush     = 1'b0;
    ID_EX_flush  = 1'b0;
    EX_MEM_stall = 1'b0;
    MEM_WB_flush = 1'b0;
    if (rst) begin
      PC_stall = 1'b0;
    end else if (w_mem_hold || w_err) begin
      PC_stall     = 1'b1;
      IF_ID_stall  = 1'b1;
      EX_MEM_stall = 1'b1;
      MEM_WB_flush = 1'b1;
    end else if (w_lu) begin
      PC_stall    = 1'b1;
      IF_ID_stall = 1'b1;
      ID_EX_flush = 1'b1;
    end else begin
      IF_flush = id_branch_taken;
    end
  end

  assign hazard_err = w_err;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (PC_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (IF_flush && (r_flush_cnt != {CNT_W{1'b1}})) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl: one task per scenario with hand-computed expectations.
module tb_pipeline_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [5:0] O_IDLE = 6'b000000;
  localparam logic [5:0] O_LU   = 6'b110010;
  localparam logic [5:0] O_MEM  = 6'b111100;
  localparam logic [5:0] O_BR   = 6'b000001;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_uses_rs, id_uses_rt, id_is_load, id_branch_taken, mem_busy;
  logic [3:0] id_rs, id_rt, id_rd;

  logic pc_s, ifid_s, if_f, idex_f, exmem_s, memwb_f, herr;
  logic [15:0] s_cnt, f_cnt;
  logic pc_s_to, ifid_s_to, if_f_to, idex_f_to, exmem_s_to, memwb_f_to, herr_to;
  logic [15:0] s_cnt_to, f_cnt_to;

  logic [5:0] outs, outs_to;
  assign outs    = {pc_s, ifid_s, exmem_s, memwb_f, idex_f, if_f};
  assign outs_to = {pc_s_to, ifid_s_to, exmem_s_to, memwb_f_to, idex_f_to, if_f_to};

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_stall_cnt = 16'd0;
  logic [15:0] exp_flush_cnt = 16'd0;
  logic cur_pc_stall = 1'b0;
  logic cur_if_flush = 1'b0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_W(4), .MEM_TIMEOUT(64), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_is_load(id_is_load),
    .id_rd(id_rd), .id_branch_taken(id_branch_taken), .mem_busy(mem_busy),
    .PC_stall(pc_s), .IF_ID_stall(ifid_s), .IF_flush(if_f), .ID_EX_flush(idex_f),
    .EX_MEM_stall(exmem_s), .MEM_WB_flush(memwb_f), .hazard_err(herr),
    .stall_cnt(s_cnt), .flush_cnt(f_cnt)
  );

  pipeline_hazard_ctrl #(.REG_W(4), .MEM_TIMEOUT(4), .CNT_W(16)) dut_to (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_is_load(id_is_load),
    .id_rd(id_rd), .id_branch_taken(id_branch_taken), .mem_busy(mem_busy),
    .PC_stall(pc_s_to), .IF_ID_stall(ifid_s_to), .IF_flush(if_f_to), .ID_EX_flush(idex_f_to),
    .EX_MEM_stall(exmem_s_to), .MEM_WB_flush(memwb_f_to), .hazard_err(herr_to),
    .stall_cnt(s_cnt_to), .flush_cnt(f_cnt_to)
  );

  task automatic set_idle();
    id_valid = 1'b0; id_rs = 4'd0; id_rt = 4'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    id_is_load = 1'b0; id_rd = 4'd0; id_branch_taken = 1'b0; mem_busy = 1'b0;
  endtask

  // Advances one clock edge while updating the reference counters for the default instance.
  task automatic tick();
    if (rst) begin
      exp_stall_cnt = 16'd0;
      exp_flush_cnt = 16'd0;
    end else begin
      if (cur_pc_stall) exp_stall_cnt = exp_stall_cnt + 16'd1;
      if (cur_if_flush) exp_flush_cnt = exp_flush_cnt + 16'd1;
    end
    cur_pc_stall = 1'b0;
    cur_if_flush = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1'b1; mem_busy = 1'b1; id_branch_taken = 1'b1; id_valid = 1'b1; id_is_load = 1'b1; id_rd = 4'd3;
    #1;
    checks++; if (outs !== O_IDLE) begin errors++; $display("[TB] FAIL rst_forced: got %b expected %b", outs, O_IDLE); end
    checks++; if (outs_to !== O_IDLE) begin errors++; $display("[TB] FAIL rst_forced_to: got %b expected %b", outs_to, O_IDLE); end
    tick(); tick();
    checks++; if (herr !== 1'b0) begin errors++; $display("[TB] FAIL rst_herr: got %b expected 0", herr); end
    checks++; if (s_cnt !== 16'd0 || f_cnt !== 16'd0) begin errors++; $display("[TB] FAIL rst_counters: got %0d/%0d expected 0/0", s_cnt, f_cnt); end
    rst = 1'b0;
    set_idle();
    id_valid = 1'b1; id_rs = 4'd3; id_uses_rs = 1'b1;
    #1;
    checks++; if (outs !== O_IDLE) begin errors++; $display("[TB] FAIL rst_tracker_clear: got %b expected %b", outs, O_IDLE); end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    id_valid = 1'b1; id_is_load = 1'b1; id_rd = 4'd3;
    #1;
    checks++; if (outs !== O_IDLE) begin errors++; $display("[TB] FAIL lu_producer: got %b expected %b", outs, O_IDLE); end
    tick();
    id_is_load = 1'b0; id_rd = 4'd5; id_rs = 4'd3; id_uses_rs = 1'b1;
    #1;
    checks++; if (outs !== O_LU) begin errors++; $display("[TB] FAIL lu_stall_rs: got %b expected %b", outs, O_LU); end
    cur_pc_stall = 1'b1;
    tick();
    checks++; if (outs !== O_IDLE) begin errors++; $display("[TB] FAIL lu_one_cycle: got %b expected %b", outs, O_IDLE); end
    tick();
    id_is_load = 1'b1; id_rd = 4'd7; id_rs = 4'd0; id_uses_rs = 1'b0;
    #1;
    tick();
    id_is_load = 1'b0; id_rd = 4'd1; id_rt = 4'd7; id_uses_rt = 1'b1;
    #1;
    checks++; if (outs !== O_LU) begin errors++; $display("[TB] FAIL lu_stall_rt: got %b expected %b", outs, O_LU); end
    cur_pc_stall = 1'b1;
    tick();
    id_is_load = 1'b1; id_rd = 4'd6; id_uses_rt = 1'b0;
    #1;
    tick();
    id_is_load = 1'b0; id_rd = 4'd2; id_rs = 4'd6; id_rt = 4'd6; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    #1;
    checks++; if (outs !== O_IDLE) begin errors++; $display("[TB] FAIL lu_unused_src: got %b expected %b", outs, O_IDLE); end
    tick();
  endtask

  task automatic test_r0();
    do_reset();
    id_valid = 1'b1; id_is_load = 1'b1; id_rd = 4'd0;
    #1;
    tick();
    id_is_load = 1'b0; id_rd = 4'd4; id_rs = 4'd0; id_rt = 4'd0; id_uses_rs = 1'b1; id_uses_rt = 1'b1;
    #1;
    checks++; if (outs !== O_IDLE) begin errors++; $display("[TB] FAIL lu_r0: got %b expected %b", outs, O_IDLE); end
    tick();
  endtask

  task automatic test_branch();
    do_reset();
    id_branch_taken = 1'b1;
    #1;
    checks++; if (outs !== O_BR) begin errors++; $display("[TB] FAIL branch_flush: got %b expected %b", outs, O_BR); end
    cur_if_flush = 1'b1;
    tick();
    id_branch_taken = 1'b0;
    #1;
    checks++; if (outs !== O_IDLE) begin errors++; $display("[TB] FAIL branch_release: got %b expected %b", outs, O_IDLE); end
    checks++; if (f_cnt !== (PERF ? 16'd1 : 16'd0)) begin errors++; $display("[TB] FAIL branch_flush_cnt: got %0d expected %0d", f_cnt, PERF ? 1 : 0); end
    tick();
  endtask

  task automatic test_mem_busy();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      mem_busy = 1'b1;
      id_branch_taken = (i == 2);
      #1;
      checks++; if (outs !== O_MEM) begin errors++; $display("[TB] FAIL mem_freeze_%0d: got %b expected %b", i, outs, O_MEM); end
      cur_pc_stall = 1'b1;
      tick();
    end
    mem_busy = 1'b0; id_branch_taken = 1'b0;
    #1;
    checks++; if (outs !== O_IDLE) begin errors++; $display("[TB] FAIL mem_release: got %b expected %b", outs, O_IDLE); end
    checks++; if (s_cnt !== (PERF ? 16'd5 : 16'd0)) begin errors++; $display("[TB] FAIL mem_stall_cnt: got %0d expected %0d", s_cnt, PERF ? 5 : 0); end
    checks++; if (herr !== 1'b0) begin errors++; $display("[TB] FAIL mem_no_err: got %b expected 0", herr); end
    tick();
  endtask

  task automatic test_mem_hold_tracker();
    do_reset();
    id_valid = 1'b1; id_is_load = 1'b1; id_rd = 4'd4;
    #1;
    tick();
    id_is_load = 1'b0; id_rd = 4'd8; id_rs = 4'd4; id_uses_rs = 1'b1; mem_busy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (outs !== O_MEM) begin errors++; $display("[TB] FAIL hold_freeze_%0d: got %b expected %b", i, outs, O_MEM); end
      cur_pc_stall = 1'b1;
      tick();
    end
    mem_busy = 1'b0;
    #1;
    checks++; if (outs !== O_LU) begin errors++; $display("[TB] FAIL hold_tracker_lu: got %b expected %b", outs, O_LU); end
    cur_pc_stall = 1'b1;
    tick();
    checks++; if (outs !== O_IDLE) begin errors++; $display("[TB] FAIL hold_lu_release: got %b expected %b", outs, O_IDLE); end
    tick();
  endtask

  task automatic test_lu_branch();
    do_reset();
    id_valid = 1'b1; id_is_load = 1'b1; id_rd = 4'd2;
    #1;
    tick();
    id_is_load = 1'b0; id_rd = 4'd9; id_rs = 4'd2; id_uses_rs = 1'b1; id_branch_taken = 1'b1;
    #1;
    checks++; if (outs !== O_LU) begin errors++; $display("[TB] FAIL lubr_stall_wins: got %b expected %b", outs, O_LU); end
    cur_pc_stall = 1'b1;
    tick();
    checks++; if (outs !== O_BR) begin errors++; $display("[TB] FAIL lubr_branch_retry: got %b expected %b", outs, O_BR); end
    cur_if_flush = 1'b1;
    tick();
    set_idle();
    #1;
    checks++; if (s_cnt !== (PERF ? exp_stall_cnt : 16'd0)) begin errors++; $display("[TB] FAIL lubr_stall_cnt: got %0d expected %0d", s_cnt, PERF ? exp_stall_cnt : 16'd0); end
    checks++; if (f_cnt !== (PERF ? exp_flush_cnt : 16'd0)) begin errors++; $display("[TB] FAIL lubr_flush_cnt: got %0d expected %0d", f_cnt, PERF ? exp_flush_cnt : 16'd0); end
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (outs_to !== O_MEM || herr_to !== 1'b0) begin errors++; $display("[TB] FAIL to_wait_%0d: got %b err %b expected %b err 0", i, outs_to, herr_to, O_MEM); end
      cur_pc_stall = 1'b1;
      tick();
    end
    checks++; if (herr_to !== 1'b1) begin errors++; $display("[TB] FAIL to_err_set: got %b expected 1", herr_to); end
    checks++; if (herr !== 1'b0) begin errors++; $display("[TB] FAIL to_long_timeout_no_err: got %b expected 0", herr); end
    mem_busy = 1'b0; id_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (outs_to !== O_MEM || herr_to !== 1'b1) begin errors++; $display("[TB] FAIL to_err_hold_%0d: got %b err %b expected %b err 1", i, outs_to, herr_to, O_MEM); end
      checks++; if (outs !== O_BR) begin errors++; $display("[TB] FAIL to_other_branch_%0d: got %b expected %b", i, outs, O_BR); end
      cur_if_flush = 1'b1;
      tick();
    end
    rst = 1'b1;
    #1;
    checks++; if (outs_to !== O_IDLE) begin errors++; $display("[TB] FAIL to_rst_forced: got %b expected %b", outs_to, O_IDLE); end
    tick();
    rst = 1'b0;
    set_idle();
    #1;
    checks++; if (outs_to !== O_IDLE || herr_to !== 1'b0) begin errors++; $display("[TB] FAIL to_after_rst: got %b err %b expected %b err 0", outs_to, herr_to, O_IDLE); end
    tick();
  endtask

  task automatic test_rst_mid_wait();
    do_reset();
    mem_busy = 1'b1;
    cur_pc_stall = 1'b1;
    tick();
    cur_pc_stall = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    checks++; if (outs !== O_IDLE) begin errors++; $display("[TB] FAIL midrst_forced: got %b expected %b", outs, O_IDLE); end
    tick();
    rst = 1'b0; mem_busy = 1'b0;
    #1;
    checks++; if (outs !== O_IDLE || outs_to !== O_IDLE) begin errors++; $display("[TB] FAIL midrst_no_residual: got %b/%b expected %b", outs, outs_to, O_IDLE); end
    tick();
  endtask

  initial begin
    set_idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_r0();
    test_branch();
    test_mem_busy();
    test_mem_hold_tracker();
    test_lu_branch();
    test_timeout();
    test_rst_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
